alu_req_arbiter: RTL and testbench

//  Sequencer/arbiter that shares one combinational N-bit ALU between two requesters.

---
 rtl/alu_req_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_req_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Two-requester sequencer for one shared combinational ALU.
// Optional macro ALU_DIV0_CHECK_EN rejects divide-by-zero at accept.
module alu_req_arbiter #(
  parameter int N           = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_op,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [N-1:0] alu_result,
  input  logic         alu_c,
  input  logic         alu_n,
  input  logic         alu_v,
  input  logic         alu_z,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err,
  output logic         busy,
  output logic [7:0]   ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [3:0]   r_cnt;
  logic         r_last;
  logic         w_idle;
  logic         w_g0;
  logic         w_g1;
  logic         w_acc;
  logic         w_bad;
  logic [N-1:0] w_a;
  logic [N-1:0] w_b;
  logic [3:0]   w_op;

  assign w_idle = (r_state == IDLE) & rst_n;

  // Round-robin only matters on contention: the loser of the last tie wins.
  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (req0_valid & req1_valid) begin
      w_g0 = r_last;
      w_g1 = ~r_last;
    end else begin
      w_g0 = req0_valid;
      w_g1 = req1_valid;
    end
  end

  assign req0_ready = w_idle & w_g0;
  assign req1_ready = w_idle & w_g1;
  assign w_acc      = req0_ready | req1_ready;

  assign w_a  = w_g1 ? req1_a  : req0_a;
  assign w_b  = w_g1 ? req1_b  : req0_b;
  assign w_op = w_g1 ? req1_op : req0_op;

`ifdef ALU_DIV0_CHECK_EN
  assign w_bad = (w_op > 4'd12) |
                 ((w_op == 4'd12) & (w_b == '0));
`else
  assign w_bad = (w_op > 4'd12);
`endif

  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_acc) w_next = w_bad ? RESP : EXEC;
      EXEC: if (r_cnt == 4'd0) w_next = RESP;
      RESP: if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_last     <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= 4'd0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= 4'd0;
      rsp_err    <= 1'b0;
      ops_done   <= 8'd0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (w_acc) begin
            alu_a  <= w_a;
            alu_b  <= w_b;
            alu_op <= w_op;
            rsp_id <= w_g1;
            r_cnt  <= 4'(EXEC_CYCLES - 1);
            if (req0_valid & req1_valid) r_last <= w_g1;
            if (w_bad) begin
              rsp_result <= '0;
              rsp_flags  <= 4'd0;
              rsp_err    <= 1'b1;
            end else begin
              rsp_err <= 1'b0;
            end
          end
        end
        EXEC: begin
          if (r_cnt == 4'd0) begin
            rsp_result <= alu_result;
            rsp_flags  <= {alu_n, alu_z, alu_c, alu_v};
            rsp_err    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: if (rsp_ready) ops_done <= ops_done + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter with a settling ALU stand-in.
// Transaction model predicts grants, latency and responses.
module tb_alu_req_arbiter;
  localparam int N  = 4;
  localparam int EX = 2;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
  } cmd_t;

  typedef struct packed {
    logic       id;
    logic [3:0] res;
    logic [3:0] flg;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [N-1:0] req0_a = '0, req0_b = '0;
  logic [N-1:0] req1_a = '0, req1_b = '0;
  logic [3:0] req0_op = '0, req1_op = '0;
  logic [N-1:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_op;
  logic alu_c, alu_n, alu_v, alu_z;
  logic rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_err, busy;
  logic [N-1:0] rsp_result;
  logic [3:0] rsp_flags;
  logic [7:0] ops_done;

  alu_req_arbiter #(.N(N), .EXEC_CYCLES(EX)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_c(alu_c), .alu_n(alu_n),
    .alu_v(alu_v), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q[$];
  bit   pend0 = 0, pend1 = 0;
  cmd_t cmd0, cmd1;
  bit   m_busy = 0;
  bit   m_last = 1;
  int   m_due = 0;
  int   m_ops = 0;

  // {result, N, Z, C, V}
  function automatic logic [7:0] alu_f(
      input logic [3:0] a, input logic [3:0] b,
      input logic [3:0] op);
    logic [4:0] t;
    logic [7:0] m;
    logic [3:0] r;
    logic c, v;
    r = 4'd0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[3:0]; c = t[4];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      4'd1: begin
        t = {1'b0, a} - {1'b0, b};
        r = t[3:0]; c = t[4];
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = ~a;
      4'd5: r = ~b;
      4'd6: r = a ^ b;
      4'd7: begin r = a << 1; c = a[3]; v = a[3] ^ a[2]; end
      4'd8: begin r = {a[3], a[3:1]}; c = a[0]; end
      4'd9: begin r = a << 1; c = a[3]; end
      4'd10: begin r = a >> 1; c = a[0]; end
      4'd11: begin m = a * b; r = m[3:0]; c = |m[7:4]; end
      4'd12: begin
        if (b == 0) begin r = 4'hF; c = 1'b1; end
        else r = a / b;
      end
      default: r = 4'd0;
    endcase
    return {r, r[3], (r == 4'd0), c, v};
  endfunction

  // ALU stand-in: wrong outputs until inputs have been stable EX cycles
  logic [11:0] last_in = '0;
  int age = 100;
  always @(negedge clk) begin
    if ({alu_a, alu_b, alu_op} != last_in) begin
      last_in <= {alu_a, alu_b, alu_op};
      age <= 1;
    end else begin
      age <= age + 1;
    end
  end

  always_comb begin
    logic [7:0] f;
    f = alu_f(alu_a, alu_b, alu_op);
    if (age < EX) f = ~f;
    alu_result = f[7:4];
    alu_n = f[3];
    alu_z = f[2];
    alu_c = f[1];
    alu_v = f[0];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic bit is_bad(input cmd_t c);
`ifdef ALU_DIV0_CHECK_EN
    return (c.op > 12) || (c.op == 12 && c.b == 0);
`else
    return c.op > 12;
`endif
  endfunction

  // Monitor: compare every presented response, pop on handshake
  always @(negedge clk) begin
    #2;
    if (rst_n && rsp_valid) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
        chk("rsp_result", 32'(rsp_result), 32'(q[0].res));
        chk("rsp_flags", 32'(rsp_flags), 32'(q[0].flg));
        chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end

  // One cycle of stimulus plus model update; called at a negedge
  task automatic step(input bit drop0, input bit drop1, input bit rr);
    bit v0, v1, g0, g1, exp_rv;
    cmd_t c;
    exp_t e;
    logic [7:0] f;
    v0 = pend0 && !drop0;
    v1 = pend1 && !drop1;
    req0_valid = v0;
    req1_valid = v1;
    {req0_a, req0_b, req0_op} = pend0 ? cmd0 : 12'($urandom);
    {req1_a, req1_b, req1_op} = pend1 ? cmd1 : 12'($urandom);
    rsp_ready = rr;
    #1;
    exp_rv = m_busy && (cyc >= m_due);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("ops_done", 32'(ops_done), 32'(m_ops % 256));
    g0 = 0;
    g1 = 0;
    if (!m_busy) begin
      if (v0 && v1) begin
        g0 = m_last;
        g1 = !m_last;
        m_last = g1;
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
    chk("req0_ready", 32'(req0_ready), 32'(g0));
    chk("req1_ready", 32'(req1_ready), 32'(g1));
    if (g0 || g1) begin
      c = g1 ? cmd1 : cmd0;
      e.id = g1;
      if (is_bad(c)) begin
        e.res = 0; e.flg = 0; e.err = 1;
        m_due = cyc + 1;
      end else begin
        f = alu_f(c.a, c.b, c.op);
        e.res = f[7:4]; e.flg = f[3:0]; e.err = 0;
        m_due = cyc + EX + 1;
      end
      q.push_back(e);
      m_busy = 1;
      if (g1) pend1 = 0;
      else pend0 = 0;
    end else if (exp_rv && rr) begin
      m_busy = 0;
      m_ops++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((pend0 || pend1 || m_busy) && n < 200) begin
      step(0, 0, 1);
      n++;
    end
    chk("drain_timeout", 32'(pend0 || pend1 || m_busy), 32'd0);
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_alu"}, 32'({alu_a, alu_b, alu_op}), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp"},
        32'({rsp_id, rsp_result, rsp_flags, rsp_err}), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ops_done"}, 32'(ops_done), 32'd0);
    chk({tag, "_ready"}, 32'({req0_ready, req1_ready}), 32'd0);
  endtask

  initial begin
    req0_valid = 1;
    req1_valid = 1;
    repeat (3) @(negedge clk);
    #1;
    zero_check("reset");
    @(negedge clk);
    rst_n = 1;
    req0_valid = 0;
    req1_valid = 0;

    // single add
    cmd0 = '{a: 4'd3, b: 4'd4, op: 4'd0}; pend0 = 1;
    drain();
    // contention, then repeated contention
    cmd0 = '{a: 4'd5, b: 4'd5, op: 4'd1}; pend0 = 1;
    cmd1 = '{a: 4'hF, b: 4'h0, op: 4'd2}; pend1 = 1;
    drain();
    for (int i = 0; i < 3; i++) begin
      cmd0 = cmd_t'({$urandom_range(0, 255), 4'($urandom_range(0, 12))});
      cmd1 = cmd_t'({$urandom_range(0, 255), 4'($urandom_range(0, 12))});
      pend0 = 1; pend1 = 1;
      drain();
    end
    // backpressure with req1 waiting
    cmd0 = '{a: 4'd7, b: 4'd9, op: 4'd0}; pend0 = 1;
    step(0, 0, 0);
    cmd1 = '{a: 4'd6, b: 4'd3, op: 4'd3}; pend1 = 1;
    repeat (8) step(0, 0, 0);
    drain();
    // illegal op from req1
    cmd1 = '{a: 4'd2, b: 4'd1, op: 4'd14}; pend1 = 1;
    drain();
    // divide by zero
    cmd0 = '{a: 4'd8, b: 4'd0, op: 4'd12}; pend0 = 1;
    drain();
    // reset mid-EXEC
    cmd0 = '{a: 4'd1, b: 4'd2, op: 4'd11}; pend0 = 1;
    step(0, 0, 1);
    step(0, 0, 1);
    rst_n = 0;
    req0_valid = 1;
    req1_valid = 1;
    #1;
    zero_check("abort");
    q.delete();
    m_busy = 0; m_last = 1; m_ops = 0;
    @(negedge clk);
    cyc++;
    rst_n = 1;
    cmd0 = '{a: 4'd9, b: 4'd9, op: 4'd6}; pend0 = 1;
    cmd1 = '{a: 4'd4, b: 4'd4, op: 4'd6}; pend1 = 1;
    drain();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (!pend0 && $urandom_range(0, 9) < 3) begin
        cmd0 = cmd_t'($urandom); pend0 = 1;
      end
      if (!pend1 && $urandom_range(0, 9) < 3) begin
        cmd1 = cmd_t'($urandom); pend1 = 1;
      end
      step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 7);
    end
    drain();
    step(0, 0, 1);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
